bep_frame_encode: RTL and testbench

Transmit-side counterpart of the BEP thermostat decode path: accepts a 12-byte thermostat frame through the same 4-bit byte-address map the decode multiplexer exposes, then serialises it onto a serial_clock/serial_data pair. Used as a frame generator for loopback self-test and as the stimulus source when emulating a thermostat on the bus. Sits between the microcontroller parallel port and the serial bus pins.

---
 rtl/bep_frame_encode.sv | 158 +++++++++++++++
 tb/tb_bep_frame_encode.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/bep_frame_encode.sv
// -----------------------------------------------------------------------------
// bep_frame_encode : stores a 12-byte BEP thermostat frame and serialises it
//                    MSB-first onto a serial_clock/serial_data pair.
// Option macro     : BEP_ENCODE_REPEAT_EN (repeat each start REPEAT_COUNT times)
// Revision         : 1.0  initial release
// -----------------------------------------------------------------------------
`default_nettype none

module bep_frame_encode #(
  parameter int HALF_PERIOD  = 4,
  parameter int GAP_CYCLES   = 16,
  parameter int REPEAT_COUNT = 3
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic [3:0] address,
  input  logic [7:0] write_data,
  input  logic       write_enable,
  input  logic       start,
  output logic       serial_clock,
  output logic       serial_data,
  output logic       busy,
  output logic       done
);

  localparam int FRAME_BYTES = 12;
  localparam int FRAME_BITS  = 8 * FRAME_BYTES;
  localparam int BIT_TIME    = 2 * HALF_PERIOD;
  localparam int PHASE_W     = $clog2(HALF_PERIOD) + 1;
  localparam int GAP_W       = $clog2(GAP_CYCLES + 1);
  localparam int REP_W       = $clog2(REPEAT_COUNT + 1);
`ifdef BEP_ENCODE_REPEAT_EN
  localparam int TX_PER_START = REPEAT_COUNT;
`else
  localparam int TX_PER_START = 1;
`endif

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_SHIFT = 2'd2,
    ST_GAP   = 2'd3
  } state_t;

  state_t                  state_q;
  logic [7:0]              regs_q [FRAME_BYTES];
  logic [FRAME_BITS-1:0]   frame_snapshot;
  logic [FRAME_BITS-1:0]   shift_q;
  logic [6:0]              bit_q;
  logic [PHASE_W-1:0]      phase_q;
  logic [GAP_W-1:0]        gap_q;
  logic [REP_W-1:0]        rep_q;
  logic                    serial_clock_q;
  logic                    busy_q;
  logic                    done_q;
  logic                    last_tx;

  // Byte 0 occupies the top of the shift register so it leaves the wire first.
  always_comb begin
    frame_snapshot = '0;
    for (int i = 0; i < FRAME_BYTES; i++) begin
      frame_snapshot[FRAME_BITS-1-8*i -: 8] = regs_q[i];
    end
  end

  assign last_tx = (int'(rep_q) == TX_PER_START - 1);

  // Writes are accepted in every state; only a later LOAD sees them.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < FRAME_BYTES; i++) begin
        regs_q[i] <= 8'h00;
      end
    end else if (write_enable && (address < 4'd12)) begin
      regs_q[address] <= write_data;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q        <= ST_IDLE;
      shift_q        <= '0;
      bit_q          <= 7'd0;
      phase_q        <= '0;
      gap_q          <= '0;
      rep_q          <= '0;
      serial_clock_q <= 1'b0;
      busy_q         <= 1'b0;
      done_q         <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          done_q <= 1'b0;
          if (start) begin
            state_q <= ST_LOAD;
            busy_q  <= 1'b1;
            rep_q   <= '0;
          end
        end

        ST_LOAD: begin
          shift_q        <= frame_snapshot;
          bit_q          <= 7'd95;
          phase_q        <= '0;
          serial_clock_q <= 1'b0;
          state_q        <= ST_SHIFT;
        end

        ST_SHIFT: begin
          if (phase_q == PHASE_W'(BIT_TIME - 1)) begin
            // Falling edge: data advances only here, giving a full half period
            // of setup and hold around the rising edge.
            phase_q        <= '0;
            serial_clock_q <= 1'b0;
            shift_q        <= {shift_q[FRAME_BITS-2:0], 1'b0};
            if (bit_q == 7'd0) begin
              state_q <= ST_GAP;
              gap_q   <= '0;
              done_q  <= last_tx && (GAP_CYCLES == 1);
            end else begin
              bit_q <= bit_q - 7'd1;
            end
          end else begin
            phase_q        <= phase_q + PHASE_W'(1);
            serial_clock_q <= (phase_q >= PHASE_W'(HALF_PERIOD - 1));
          end
        end

        ST_GAP: begin
          if (gap_q == GAP_W'(GAP_CYCLES - 1)) begin
            done_q <= 1'b0;
            if (last_tx) begin
              state_q <= ST_IDLE;
              busy_q  <= 1'b0;
            end else begin
              state_q <= ST_LOAD;
              rep_q   <= rep_q + REP_W'(1);
            end
          end else begin
            gap_q  <= gap_q + GAP_W'(1);
            // Look ahead one cycle so the pulse lands in the final gap cycle.
            done_q <= last_tx && (int'(gap_q) + 2 == GAP_CYCLES);
          end
        end

        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign serial_clock = serial_clock_q;
  assign serial_data  = shift_q[FRAME_BITS-1];
  assign busy         = busy_q;
  assign done         = done_q;

endmodule

`default_nettype wire

// File: tb/tb_bep_frame_encode.sv
// -----------------------------------------------------------------------------
// tb_bep_frame_encode : self-checking bench for bep_frame_encode
// Revision            : 1.0  initial release
// -----------------------------------------------------------------------------
`default_nettype none

module tb_bep_frame_encode;

  localparam int HP  = 2;
  localparam int GAP = 5;
  localparam int REP = 3;
`ifdef BEP_ENCODE_REPEAT_EN
  localparam int TX = REP;
`else
  localparam int TX = 1;
`endif
  localparam int TX_CYCLES = 1 + 96 * 2 * HP + GAP;

  logic       clock;
  logic       reset_n;
  logic [3:0] address;
  logic [7:0] write_data;
  logic       write_enable;
  logic       start;
  logic       serial_clock;
  logic       serial_data;
  logic       busy;
  logic       done;

  int tests = 0;
  int fails = 0;
  logic [7:0] model [12];

  bep_frame_encode #(
    .HALF_PERIOD (HP),
    .GAP_CYCLES  (GAP),
    .REPEAT_COUNT(REP)
  ) dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .address     (address),
    .write_data  (write_data),
    .write_enable(write_enable),
    .start       (start),
    .serial_clock(serial_clock),
    .serial_data (serial_data),
    .busy        (busy),
    .done        (done)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic check(input string tag, input logic [95:0] obs, input logic [95:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  function automatic logic [95:0] model_frame();
    logic [95:0] f;
    f = '0;
    for (int i = 0; i < 12; i++) f = f * 256 + 96'(model[i]);
    return f;
  endfunction

  task automatic write_byte(input logic [3:0] a, input logic [7:0] d);
    address      = a;
    write_data   = d;
    write_enable = 1'b1;
    tick();
    write_enable = 1'b0;
    if (a < 4'd12) model[a] = d;
  endtask

  // Starts a transmission, watches it to completion and checks bits/timing.
  task automatic run_frame(input string tag, input int mid_n, input logic [3:0] mid_a,
                           input logic [7:0] mid_d, input bit mid_we, input bit mid_start,
                           input bit hold);
    logic [95:0] exp0, exp_rep, got;
    bit   bits[$];
    int   n, busy_cyc, done_cnt, done_n, fall_n, first_rise, viol, k;
    logic prev_sclk, prev_sdata;
    exp0 = model_frame();
    n = 0; busy_cyc = 0; done_cnt = 0; done_n = -1; fall_n = -1; first_rise = -1; viol = 0;
    prev_sclk = 1'b0; prev_sdata = 1'b0;
    start = 1'b1;
    while (fall_n < 0 && n < TX * TX_CYCLES + 50) begin
      tick();
      n++;
      if (n == 1) check({tag, "_load_busy"}, 96'(busy), 96'd1);
      if (n == 2) check({tag, "_first_bit"}, 96'(serial_data), 96'(exp0[95]));
      if (busy === 1'b1) busy_cyc++;
      else if (n > 1) fall_n = n;
      if (done === 1'b1) begin done_cnt++; done_n = n; end
      if (serial_clock === 1'b1 && prev_sclk === 1'b0) begin
        bits.push_back(serial_data);
        if (first_rise < 0) first_rise = n;
      end
      if (serial_clock === 1'b1 && prev_sclk === 1'b1 && serial_data !== prev_sdata) viol++;
      prev_sclk  = serial_clock;
      prev_sdata = serial_data;
      start        = hold || (mid_start && n == mid_n);
      write_enable = mid_we && (n == mid_n);
      address      = mid_a;
      write_data   = mid_d;
    end
    write_enable = 1'b0;
    if (mid_we && mid_a < 4'd12) model[mid_a] = mid_d;
    exp_rep = model_frame();
    check({tag, "_terminated"}, 96'(fall_n > 0), 96'd1);
    check({tag, "_busy_len"}, 96'(busy_cyc), 96'(TX * TX_CYCLES));
    check({tag, "_done_count"}, 96'(done_cnt), 96'd1);
    check({tag, "_done_pos"}, 96'(done_n), 96'(fall_n - 1));
    check({tag, "_first_rise"}, 96'(first_rise), 96'(2 + HP));
    check({tag, "_bit_count"}, 96'(bits.size()), 96'(96 * TX));
    check({tag, "_hold_violations"}, 96'(viol), 96'd0);
    for (int f = 0; f < TX; f++) begin
      got = '0;
      for (int b = 0; b < 96; b++)
        got = {got[94:0], (96 * f + b < bits.size()) ? bits[96 * f + b] : 1'b0};
      check({tag, "_frame"}, got, (f == 0) ? exp0 : exp_rep);
    end
    if (hold) begin
      tick();
      check({tag, "_b2b_reload"}, 96'(busy), 96'd1);
      start = 1'b0;
      k = 0;
      while (busy !== 1'b0 && k < TX * TX_CYCLES + 50) begin tick(); k++; end
      check({tag, "_b2b_drain"}, 96'(busy), 96'd0);
    end
    start = 1'b0;
  endtask

  initial begin
    reset_n = 1'b0; address = 4'd0; write_data = 8'h00; write_enable = 1'b0; start = 1'b0;
    for (int i = 0; i < 12; i++) model[i] = 8'h00;
    repeat (3) tick();
    check("reset_outputs", 96'({serial_clock, serial_data, busy, done}), 96'd0);
    reset_n = 1'b1;
    tick();
    check("idle_outputs", 96'({serial_clock, serial_data, busy, done}), 96'd0);

    // Directed thermostat frame: EF BE AD DE D2 00 DC 00 05 11 22 33
    write_byte(4'd0, 8'hEF); write_byte(4'd1, 8'hBE); write_byte(4'd2, 8'hAD);
    write_byte(4'd3, 8'hDE); write_byte(4'd4, 8'hD2); write_byte(4'd5, 8'h00);
    write_byte(4'd6, 8'hDC); write_byte(4'd7, 8'h00); write_byte(4'd8, 8'h05);
    write_byte(4'd9, 8'h11); write_byte(4'd10, 8'h22); write_byte(4'd11, 8'h33);
    check("model_literal", model_frame(), 96'hEFBEADDE_D200DC00_05112233);
    run_frame("basic", 0, 4'd0, 8'h00, 1'b0, 1'b0, 1'b0);

    run_frame("wr_busy", 100, 4'd8, 8'hA5, 1'b1, 1'b0, 1'b0);
    run_frame("after_wr", 0, 4'd0, 8'h00, 1'b0, 1'b0, 1'b0);

    run_frame("start_busy", 60, 4'd12, 8'hFF, 1'b1, 1'b1, 1'b0);
    write_byte(4'd13, 8'h5A);
    write_byte(4'd15, 8'hC3);
    run_frame("unchanged", 0, 4'd0, 8'h00, 1'b0, 1'b0, 1'b0);

    for (int r = 0; r < 3; r++) begin
      for (int w = 0; w < 12; w++)
        write_byte(4'($urandom_range(0, 15)), 8'($urandom));
      run_frame($sformatf("rand%0d", r), int'($urandom_range(10, 300)),
                4'($urandom_range(0, 15)), 8'($urandom), 1'b1, 1'($urandom), 1'b0);
    end

    run_frame("b2b", 0, 4'd0, 8'h00, 1'b0, 1'b0, 1'b1);

    // Asynchronous reset in the middle of a transmission.
    write_byte(4'd0, 8'h81);
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (30) tick();
    #2 reset_n = 1'b0;
    #1 check("reset_async", 96'({serial_clock, serial_data, busy, done}), 96'd0);
    for (int i = 0; i < 12; i++) model[i] = 8'h00;
    tick();
    reset_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("idle_after_reset", 96'({serial_clock, serial_data, busy, done}), 96'd0);
    end
    run_frame("zero_frame", 0, 4'd0, 8'h00, 1'b0, 1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
